// File: rtl/riscv_wb_arbiter.sv
// Three-source round-robin writeback arbiter and pending-write scoreboard. Write port is registered, so commits land one cycle after the grant.
// Backpressure: req_ready is a combinational one-hot grant, and a source holds its request until it is granted.
module riscv_wb_arbiter #(
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          req_valid,
  input  logic [14:0]         req_rd,
  input  logic [3*DATA_W-1:0] req_data,
  output logic [2:0]          req_ready,
  output logic                we3,
  output logic [4:0]          wa3,
  output logic [DATA_W-1:0]   wd3,
  input  logic                iss_valid,
  input  logic [4:0]          iss_rd,
  input  logic [4:0]          ra1,
  input  logic [4:0]          ra2,
  output logic                busy1,
  output logic                busy2,
  output logic                stall,
  output logic                err
);

  generate
    if (DATA_W != 32) begin : g_bad_width
      $error("riscv_wb_arbiter supports DATA_W = 32 only");
    end
  endgenerate

  logic [1:0]        ptr;
  logic [1:0]        gnt_idx;
  logic              xfer;
  logic [4:0]        sel_rd;
  logic [DATA_W-1:0] sel_data;
  logic [31:0]       busy;
  logic [31:0]       busy_nxt;
  logic [1:0]        order [3];

  // Search order starts one past the last granted source.
  always_comb begin
    order[0] = 2'd0;
    order[1] = 2'd1;
    order[2] = 2'd2;
    case (ptr)
      2'd0: begin
        order[0] = 2'd1;
        order[1] = 2'd2;
        order[2] = 2'd0;
      end
      2'd1: begin
        order[0] = 2'd2;
        order[1] = 2'd0;
        order[2] = 2'd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    req_ready = 3'b000;
    gnt_idx   = ptr;
    xfer      = 1'b0;
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (!xfer && req_valid[order[k]]) begin
          xfer               = 1'b1;
          gnt_idx            = order[k];
          req_ready[order[k]] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    case (gnt_idx)
      2'd0: begin
        sel_rd   = req_rd[4:0];
        sel_data = req_data[DATA_W-1:0];
      end
      2'd1: begin
        sel_rd   = req_rd[9:5];
        sel_data = req_data[2*DATA_W-1:DATA_W];
      end
      default: begin
        sel_rd   = req_rd[14:10];
        sel_data = req_data[3*DATA_W-1:2*DATA_W];
      end
    endcase
  end

  // A new issue to the register being committed keeps it pending.
  always_comb begin
    busy_nxt = busy;
    if (we3) busy_nxt[wa3] = 1'b0;
    if (iss_valid && (iss_rd != 5'd0)) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we3  <= 1'b0;
      wa3  <= 5'd0;
      wd3  <= '0;
      busy <= 32'd0;
      ptr  <= 2'd2;
      err  <= 1'b0;
    end else begin
      busy <= busy_nxt;
      if (we3 && !busy[wa3]) err <= 1'b1;
      we3 <= xfer && (sel_rd != 5'd0);
      if (xfer) ptr <= gnt_idx;
      if (xfer && (sel_rd != 5'd0)) begin
        wa3 <= sel_rd;
        wd3 <= sel_data;
      end
    end
  end

  assign busy1 = busy[ra1];
  assign busy2 = busy[ra2];
  assign stall = busy1 | busy2;

endmodule

// File: doc/riscv_wb_arbiter.md
RISCV_WB_ARBITER -- requirements
Module: riscv_wb_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, writeback data width; the block SHALL support only the value 32.
REQ-002 Port: clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Port: rst  in  1  reset, synchronous, active-high.
REQ-004 Port: req_valid  in  3  per-source writeback request (src0 ALU, src1 LSU, src2 MUL/DIV).
REQ-005 Port: req_rd  in  15  destination register; src i at bits [5i+4:5i].
REQ-006 Port: req_data  in  96  writeback data; src i at bits [32i+31:32i].
REQ-007 Port: req_ready  out  3  one-hot grant; combinational.
REQ-008 Port: we3  out  1  regfile write enable; registered.
REQ-009 Port: wa3  out  5  regfile write address; registered.
REQ-010 Port: wd3  out  32  regfile write data; registered.
REQ-011 Port: iss_valid  in  1  an instruction with destination iss_rd is issued this cycle.
REQ-012 Port: iss_rd  in  5  destination of the issued instruction.
REQ-013 Port: ra1, ra2  in  5 each  source registers to check for pending writes.
REQ-014 Port: busy1, busy2  out  1 each  pending-write flag for ra1/ra2; combinational.
REQ-015 Port: stall  out  1  busy1 | busy2; combinational.
REQ-016 Port: err  out  1  sticky protocol-error flag; registered.

Function
REQ-017 Transfer on src i SHALL occur when req_valid[i] && req_ready[i].
REQ-018 req_ready SHALL be zero when no source is valid or when rst=1; otherwise it SHALL be exactly one-hot.
REQ-019 Arbitration SHALL be round-robin: search sources from (ptr+1) mod 3 upward and grant the first valid one.
REQ-020 ptr (2 bits, values 0..2) SHALL load the granted index on a transfer and SHALL hold otherwise.
REQ-021 req_ready[i] MAY depend on req_valid; a source SHALL hold req_valid, req_rd and req_data stable until its transfer.
REQ-022 The cycle after a transfer with rd!=0: we3=1, wa3=rd, wd3=data (1-cycle latency).
REQ-023 A transfer with rd=0 SHALL be consumed; the following cycle SHALL have we3=0.
REQ-024 In a cycle after no transfer, we3=0 and wa3/wd3 SHALL hold their previous values.
REQ-025 Throughput SHALL be one writeback per cycle; back-to-back grants SHALL be allowed.
REQ-026 Scoreboard busy[31:0]: busy[0] SHALL be constant 0.
REQ-027 At an edge with iss_valid && iss_rd!=0, busy[iss_rd] SHALL be set.
REQ-028 At an edge with we3=1, busy[wa3] SHALL clear; this is the same edge on which the regfile commits.
REQ-029 When set and clear target the same index at the same edge, set SHALL win.
REQ-030 busy1 SHALL equal busy[ra1] and busy2 SHALL equal busy[ra2]; there SHALL be no bypass from the pending we3.
REQ-031 err SHALL set at an edge where we3=1 and busy[wa3]=0; only rst SHALL clear it.

Reset
REQ-032 At an edge with rst=1, the block SHALL set we3=0, wa3=0, wd3=0, busy=0, ptr=2 and err=0.
REQ-033 Reset mid-operation: an in-flight registered write SHALL be dropped (we3=0 the next cycle), and a request presented during reset SHALL NOT transfer.
REQ-034 After reset, src0 SHALL have first priority.

Verification
REQ-035 Reset, then src1 valid (rd=5, data=0xDEADBEEF) -> req_ready=3'b010; next cycle we3=1, wa3=5, wd3=0xDEADBEEF.
REQ-036 All three sources held valid for 6 cycles -> grant order 0,1,2,0,1,2 and we3=1 on every cycle from the 2nd to the 7th.
REQ-037 iss_valid with iss_rd=7, then ra1=7 -> busy1=1 and stall=1 until the edge with we3=1, wa3=7; the cycle after that edge busy1=0.
REQ-038 iss_rd=3 issued at the same edge where we3=1, wa3=3 -> busy[3]=1 afterwards and err=0.
REQ-039 src2 transfer with rd=0 -> req_ready[2]=1, next cycle we3=0, and ptr advances to 2.
REQ-040 we3 commit to wa3=9 with busy[9]=0 -> err=1 and it stays 1; rst pulse mid-stream -> err=0, busy=0, we3=0 on the next cycle.
